// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit between the MEM stage and a variable-latency data memory.
// It aligns the address, builds byte enables and replicated store data, and runs a
// request/grant/response handshake while stalling the pipeline. Load data is
// extracted from its byte lanes and sign- or zero-extended.

`ifndef RISCV_LITTLE_ENDIAN
`define RISCV_LITTLE_ENDIAN 0
`endif
`ifndef RISCV_BIG_ENDIAN
`define RISCV_BIG_ENDIAN 1
`endif

module riscv_lsu #(
    parameter int MP_DATA_WIDTH = 32,
    parameter int MP_ADDR_WIDTH = 32,
    parameter int MP_ENDIANESS  = `RISCV_BIG_ENDIAN
) (
    input  logic                       iclk,
    input  logic                       irstn,
    input  logic                       ireq_valid,
    input  logic                       ireq_we,
    input  logic [1:0]                 ireq_size,
    input  logic                       ireq_unsigned,
    input  logic [MP_ADDR_WIDTH-1:0]   ireq_addr,
    input  logic [MP_DATA_WIDTH-1:0]   ireq_wdata,
    input  logic [4:0]                 ird,
    output logic                       ostall,
    output logic                       ords_valid,
    output logic [4:0]                 ords_rd,
    output logic [MP_DATA_WIDTH-1:0]   ords_data,
    output logic                       omisaligned,
    output logic                       oerr,
    output logic                       omem_req,
    output logic                       omem_we,
    output logic [MP_ADDR_WIDTH-1:0]   omem_addr,
    output logic [MP_DATA_WIDTH/8-1:0] omem_be,
    output logic [MP_DATA_WIDTH-1:0]   omem_wdata,
    input  logic                       imem_gnt,
    input  logic                       imem_rvalid,
    input  logic [MP_DATA_WIDTH-1:0]   imem_rdata,
    input  logic                       imem_err
);

    localparam int NB = MP_DATA_WIDTH / 8;
    localparam int LW = $clog2(NB);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t                     state_q, state_d;
    logic [MP_ADDR_WIDTH-1:0]   addr_q;
    logic                       we_q;
    logic [NB-1:0]              be_q;
    logic [MP_DATA_WIDTH-1:0]   wdata_q;
    logic [1:0]                 size_q;
    logic                       uns_q;
    logic [LW-1:0]              first_q;
    logic [4:0]                 rd_q;
    logic                       err_q;
    logic [MP_DATA_WIDTH-1:0]   data_q;

    logic [LW-1:0]              offset;
    logic [3:0]                 nBytes;
    logic [3:0]                 firstLane;
    logic                       misaligned;
    logic [NB-1:0]              beMask;
    logic [NB-1:0]              beNew;
    logic [MP_DATA_WIDTH-1:0]   wdataRep;
    logic                       reqLive;
    logic                       accept;
    logic [MP_DATA_WIDTH-1:0]   shifted;
    logic [MP_DATA_WIDTH-1:0]   fieldMask;
    logic                       signBit;
    logic [MP_DATA_WIDTH-1:0]   loadFmt;

    // A request held during reset must not stall or be flagged, so reset masks it.
    assign reqLive = ireq_valid & irstn;
    assign accept  = (state_q == IDLE) & reqLive & ~misaligned;

    // Decode the incoming request: alignment check, first byte lane, enables and replicated data.
    always_comb begin
        offset    = ireq_addr[LW-1:0];
        nBytes    = 4'd1 << ireq_size;
        firstLane = (MP_ENDIANESS == `RISCV_BIG_ENDIAN) ? (4'(NB) - nBytes - 4'(offset))
                                                       : 4'(offset);
        misaligned = 1'b0;
        beMask     = '1;
        wdataRep   = ireq_wdata;
        case (ireq_size)
            2'd0: begin
                beMask   = NB'(1);
                wdataRep = {NB{ireq_wdata[7:0]}};
            end
            2'd1: begin
                misaligned = offset[0];
                beMask     = NB'(3);
                wdataRep   = {(NB/2){ireq_wdata[15:0]}};
            end
            2'd2: begin
                misaligned = |offset[1:0];
                beMask     = NB'(15);
                wdataRep   = {(NB/4){ireq_wdata[31:0]}};
            end
            default: begin
                misaligned = (NB == 4) || (|offset);
            end
        endcase
        beNew = beMask << firstLane[LW-1:0];
    end

    // Shift the addressed field down to bit 0 and sign- or zero-extend it.
    always_comb begin
        shifted   = imem_rdata >> {first_q, 3'b000};
        fieldMask = '1;
        signBit   = shifted[MP_DATA_WIDTH-1];
        case (size_q)
            2'd0: begin
                fieldMask = MP_DATA_WIDTH'(8'hFF);
                signBit   = shifted[7];
            end
            2'd1: begin
                fieldMask = MP_DATA_WIDTH'(16'hFFFF);
                signBit   = shifted[15];
            end
            2'd2: begin
                fieldMask = MP_DATA_WIDTH'(32'hFFFF_FFFF);
                signBit   = shifted[31];
            end
            default: ;
        endcase
        loadFmt = (shifted & fieldMask) | ((~uns_q & signBit) ? ~fieldMask : '0);
    end

    // State register; reset abandons any access in flight.
    always_ff @(posedge iclk or negedge irstn) begin
        if (!irstn) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic and the handshake/stall outputs.
    always_comb begin
        state_d     = state_q;
        omem_req    = 1'b0;
        ostall      = 1'b0;
        ords_valid  = 1'b0;
        oerr        = 1'b0;
        omisaligned = 1'b0;
        case (state_q)
            IDLE: begin
                omisaligned = reqLive & misaligned;
                ostall      = accept;
                if (accept) state_d = REQ;
            end
            REQ: begin
                omem_req = 1'b1;
                ostall   = 1'b1;
                if (imem_gnt) state_d = we_q ? DONE : WAIT;
            end
            WAIT: begin
                ostall = 1'b1;
                if (imem_rvalid) state_d = DONE;
            end
            DONE: begin
                ords_valid = ~we_q & ~err_q;
                oerr       = err_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture the request on accept, then the store error or the formatted load result.
    always_ff @(posedge iclk or negedge irstn) begin
        if (!irstn) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            first_q <= '0;
            rd_q    <= 5'd0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            if (accept) begin
                addr_q  <= {ireq_addr[MP_ADDR_WIDTH-1:LW], {LW{1'b0}}};
                we_q    <= ireq_we;
                be_q    <= beNew;
                wdata_q <= wdataRep;
                size_q  <= ireq_size;
                uns_q   <= ireq_unsigned;
                first_q <= firstLane[LW-1:0];
                rd_q    <= ird;
                err_q   <= 1'b0;
            end
            if ((state_q == REQ) && imem_gnt && we_q) begin
                err_q <= imem_err;
            end
            if ((state_q == WAIT) && imem_rvalid) begin
                data_q <= loadFmt;
                err_q  <= imem_err;
            end
        end
    end

    assign omem_we    = (state_q == REQ) & we_q;
    assign omem_be    = (state_q == REQ) ? be_q : '0;
    assign omem_addr  = addr_q;
    assign omem_wdata = wdata_q;
    assign ords_rd    = rd_q;
    assign ords_data  = data_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: drives three LSU instances (LE 32-bit, BE 32-bit, LE 64-bit) with a
// table of fixed accesses, a randomized stream checked against a byte-address model,
// and hand-written reset-mid-access sequences.

`ifndef RISCV_LITTLE_ENDIAN
`define RISCV_LITTLE_ENDIAN 0
`endif
`ifndef RISCV_BIG_ENDIAN
`define RISCV_BIG_ENDIAN 1
`endif

module tb_riscv_lsu;

    typedef struct packed {
        logic        stall;
        logic        rdsValid;
        logic [4:0]  rdsRd;
        logic [63:0] rdsData;
        logic        mis;
        logic        err;
        logic        memReq;
        logic        memWe;
        logic [31:0] memAddr;
        logic [7:0]  memBe;
        logic [63:0] memWdata;
    } outs_t;

    typedef struct {
        int          inst;
        bit          we;
        bit [1:0]    size;
        bit          uns;
        bit [31:0]   addr;
        bit [63:0]   wdata;
        bit [63:0]   rdata;
        bit [4:0]    rd;
        int          gntDly;
        int          rvDly;
        bit          err;
        bit          expMis;
        bit [31:0]   expAddr;
        bit [7:0]    expBe;
        bit [63:0]   expWdata;
        bit [63:0]   expData;
        int          expStall;
    } vec_t;

    logic        clk;
    logic        rstn;
    logic        reqValid  [3];
    logic        reqWe     [3];
    logic [1:0]  reqSize   [3];
    logic        reqUns    [3];
    logic [31:0] reqAddr   [3];
    logic [63:0] reqWdata  [3];
    logic [4:0]  reqRd     [3];
    logic        memGnt    [3];
    logic        memRvalid [3];
    logic [63:0] memRdata  [3];
    logic        memErr    [3];
    outs_t       outs      [3];

    int nCompared   = 0;
    int nMismatched = 0;
    int curVec      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gDut
        localparam int W   = (g == 2) ? 64 : 32;
        localparam int NB  = W / 8;
        localparam int END = (g == 1) ? `RISCV_BIG_ENDIAN : `RISCV_LITTLE_ENDIAN;
        logic          stall, rv, mis, err, req, we;
        logic [4:0]    rd;
        logic [W-1:0]  data, wd;
        logic [31:0]   addr;
        logic [NB-1:0] be;
        outs_t         pk;

        riscv_lsu #(.MP_DATA_WIDTH(W), .MP_ADDR_WIDTH(32), .MP_ENDIANESS(END)) dut (
            .iclk(clk), .irstn(rstn),
            .ireq_valid(reqValid[g]), .ireq_we(reqWe[g]), .ireq_size(reqSize[g]),
            .ireq_unsigned(reqUns[g]), .ireq_addr(reqAddr[g]), .ireq_wdata(reqWdata[g][W-1:0]),
            .ird(reqRd[g]),
            .ostall(stall), .ords_valid(rv), .ords_rd(rd), .ords_data(data),
            .omisaligned(mis), .oerr(err),
            .omem_req(req), .omem_we(we), .omem_addr(addr), .omem_be(be), .omem_wdata(wd),
            .imem_gnt(memGnt[g]), .imem_rvalid(memRvalid[g]),
            .imem_rdata(memRdata[g][W-1:0]), .imem_err(memErr[g])
        );

        assign pk = {stall, rv, rd, 64'(data), mis, err, req, we, addr, 8'(be), 64'(wd)};
    end

    // Gather every instance's outputs into one indexable array.
    always_comb begin
        outs[0] = gDut[0].pk;
        outs[1] = gDut[1].pk;
        outs[2] = gDut[2].pk;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s vec=%0d: got 0x%0h, expected 0x%0h", name, curVec, act, exp);
        end
    endtask

    // Reference: map each byte address of the access to its lane, then assemble by endianness.
    function automatic vec_t fillExpected(input vec_t vi);
        vec_t v = vi;
        int nb  = (v.inst == 2) ? 8 : 4;
        bit big = (v.inst == 1);
        int n   = 1 << v.size;
        int off = int'(v.addr % nb);
        v.expMis   = ((off % n) != 0) || (n > nb);
        v.expAddr  = v.addr - 32'(off);
        v.expBe    = '0;
        v.expWdata = '0;
        v.expData  = '0;
        v.expStall = 0;
        if (!v.expMis) begin
            for (int k = 0; k < n; k++) begin
                int lane = big ? (nb - 1 - (off + k)) : (off + k);
                v.expBe[lane] = 1'b1;
                v.expData |= 64'(v.rdata[lane*8 +: 8]) << (8 * (big ? (n - 1 - k) : k));
            end
            if (!v.uns && v.expData[8*n-1]) v.expData |= ~((64'd1 << (8 * n)) - 64'd1);
            if (nb == 4) v.expData &= 64'hFFFF_FFFF;
            for (int i = 0; i < nb; i++) v.expWdata[i*8 +: 8] = v.wdata[(i % n)*8 +: 8];
            v.expStall = v.we ? (2 + v.gntDly) : (3 + v.gntDly + v.rvDly);
        end
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        int  k = v.inst;
        int  cyc = 0, stallCnt = 0, gc = 0, rc = 0;
        bit  granted = 0, rvSent = 0, doneNext = 0, done = 0, spurious = 0;
        @(negedge clk);
        reqValid[k] = 1'b1;  reqWe[k] = v.we;        reqSize[k] = v.size;
        reqUns[k]   = v.uns; reqAddr[k] = v.addr;    reqWdata[k] = v.wdata;
        reqRd[k]    = v.rd;  memGnt[k] = 1'b0;       memRvalid[k] = 1'b0; memErr[k] = 1'b0;
        #1;
        checkOutput("misaligned", 64'(outs[k].mis), 64'(v.expMis));
        if (v.expMis) begin
            checkOutput("misStall", 64'(outs[k].stall), 64'd0);
            checkOutput("misReq", 64'(outs[k].memReq), 64'd0);
            @(negedge clk);
            reqValid[k] = 1'b0;
            #1;
            checkOutput("misNoAccess", 64'({outs[k].memReq, outs[k].rdsValid, outs[k].err}), 64'd0);
            return;
        end
        while (!done && cyc < 50) begin
            if (outs[k].stall) stallCnt++;
            if (doneNext) begin
                checkOutput("doneValid", 64'(outs[k].rdsValid), 64'(!v.we && !v.err));
                checkOutput("doneErr", 64'(outs[k].err), 64'(v.err));
                if (!v.we && !v.err) begin
                    checkOutput("loadData", outs[k].rdsData, v.expData);
                    checkOutput("loadRd", 64'(outs[k].rdsRd), 64'(v.rd));
                end
                memGnt[k] = 1'b0; memRvalid[k] = 1'b0; memErr[k] = 1'b0;
                reqValid[k] = 1'b0;
                done = 1;
            end else begin
                if (outs[k].rdsValid || outs[k].err) spurious = 1;
                memGnt[k] = 1'b0; memRvalid[k] = 1'b0; memErr[k] = 1'b0;
                if (outs[k].memReq) begin
                    checkOutput("memAddr", 64'(outs[k].memAddr), 64'(v.expAddr));
                    checkOutput("memBe", 64'(outs[k].memBe), 64'(v.expBe));
                    checkOutput("memWe", 64'(outs[k].memWe), 64'(v.we));
                    if (v.we) checkOutput("memWdata", outs[k].memWdata, v.expWdata);
                    if (gc == v.gntDly) begin
                        memGnt[k] = 1'b1;
                        memErr[k] = v.we & v.err;
                        granted   = 1;
                        if (v.we) doneNext = 1;
                    end else begin
                        gc++;
                    end
                end else if (granted && !v.we && !rvSent) begin
                    if (rc == v.rvDly) begin
                        memRvalid[k] = 1'b1;
                        memRdata[k]  = v.rdata;
                        memErr[k]    = v.err;
                        rvSent       = 1;
                        doneNext     = 1;
                    end else begin
                        rc++;
                    end
                end
            end
            if (!done) begin
                @(negedge clk);
                #1;
                cyc++;
            end
        end
        checkOutput("completion", 64'(done), 64'd1);
        checkOutput("stallCycles", 64'(stallCnt), 64'(v.expStall));
        checkOutput("noSpurious", 64'(spurious), 64'd0);
        @(negedge clk);
        #1;
        checkOutput("idleAfter", 64'({outs[k].memReq, outs[k].stall}), 64'd0);
    endtask

    task automatic resetDuringAccess(input bit inWait);
        bit seen = 0;
        curVec = inWait ? 200 : 201;
        @(negedge clk);
        reqValid[0] = 1'b1; reqWe[0] = 1'b0; reqSize[0] = 2'd2; reqUns[0] = 1'b0;
        reqAddr[0] = 32'h40; reqRd[0] = 5'd7;
        #1;
        checkOutput("rstSeqAccept", 64'(outs[0].stall), 64'd1);
        @(negedge clk);
        #1;
        checkOutput("rstSeqReq", 64'(outs[0].memReq), 64'd1);
        if (inWait) begin
            memGnt[0] = 1'b1;
            @(negedge clk);
            memGnt[0] = 1'b0;
            #1;
            checkOutput("rstSeqWait", 64'({outs[0].memReq, outs[0].stall}), 64'b01);
        end
        rstn = 1'b0;
        #1;
        checkOutput("rstDropReq", 64'(outs[0].memReq), 64'd0);
        checkOutput("rstDropStall", 64'(outs[0].stall), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        reqValid[0] = 1'b0;
        #1;
        memRvalid[0] = 1'b1;
        memRdata[0]  = 64'h1234_5678;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            memRvalid[0] = 1'b0;
            #1;
            if (outs[0].rdsValid || outs[0].err || outs[0].memReq || outs[0].stall) seen = 1;
        end
        checkOutput("rstIgnoreRvalid", 64'(seen), 64'd0);
    endtask

    initial begin
        vec_t vecs [14];
        vec_t rv;
        //         inst we sz uns addr          wdata                  rdata                  rd    g  r  err mis expAddr       expBe  expWdata               expData                stall
        vecs[0]  = '{0, 0, 0, 0, 32'h1003, 64'h0,                 64'h8000_0000,          5'd1, 0, 0, 0, 0, 32'h1000, 8'h08, 64'h0,                 64'hFFFF_FF80,          3};
        vecs[1]  = '{1, 1, 1, 0, 32'h2002, 64'hBEEF,              64'h0,                  5'd2, 2, 0, 0, 0, 32'h2000, 8'h03, 64'hBEEF_BEEF,         64'h0,                  4};
        vecs[2]  = '{0, 0, 2, 0, 32'h1002, 64'h0,                 64'h0,                  5'd3, 0, 0, 0, 1, 32'h0,    8'h00, 64'h0,                 64'h0,                  0};
        vecs[3]  = '{2, 0, 3, 0, 32'h0008, 64'h0,                 64'h0123_4567_89AB_CDEF, 5'd4, 0, 0, 0, 0, 32'h0008, 8'hFF, 64'h0,                64'h0123_4567_89AB_CDEF, 3};
        vecs[4]  = '{2, 0, 3, 0, 32'h0004, 64'h0,                 64'h0,                  5'd5, 0, 0, 0, 1, 32'h0,    8'h00, 64'h0,                 64'h0,                  0};
        vecs[5]  = '{0, 0, 2, 0, 32'h0100, 64'h0,                 64'h5555_AAAA,          5'd6, 0, 1, 1, 0, 32'h0100, 8'h0F, 64'h0,                 64'h0,                  4};
        vecs[6]  = '{1, 0, 1, 0, 32'h0002, 64'h0,                 64'h1234_ABCD,          5'd8, 0, 0, 0, 0, 32'h0000, 8'h03, 64'h0,                 64'hFFFF_ABCD,          3};
        vecs[7]  = '{1, 0, 0, 0, 32'h0000, 64'h0,                 64'h7F00_0000,          5'd9, 1, 2, 0, 0, 32'h0000, 8'h08, 64'h0,                 64'h0000_007F,          6};
        vecs[8]  = '{0, 1, 0, 0, 32'h0011, 64'hA5,                64'h0,                  5'd10, 0, 0, 0, 0, 32'h0010, 8'h02, 64'hA5A5_A5A5,        64'h0,                  2};
        vecs[9]  = '{0, 1, 2, 0, 32'h0020, 64'hCAFE_F00D,         64'h0,                  5'd11, 1, 0, 1, 0, 32'h0020, 8'h0F, 64'hCAFE_F00D,        64'h0,                  3};
        vecs[10] = '{2, 0, 2, 1, 32'h004C, 64'h0,                 64'hDEAD_BEEF_0000_0000, 5'd12, 0, 0, 0, 0, 32'h0048, 8'hF0, 64'h0,               64'h0000_0000_DEAD_BEEF, 3};
        vecs[11] = '{1, 0, 1, 0, 32'h0003, 64'h0,                 64'h0,                  5'd13, 0, 0, 0, 1, 32'h0,    8'h00, 64'h0,                 64'h0,                  0};
        vecs[12] = '{1, 0, 3, 0, 32'h0000, 64'h0,                 64'h0,                  5'd14, 0, 0, 0, 1, 32'h0,    8'h00, 64'h0,                 64'h0,                  0};
        vecs[13] = '{2, 1, 1, 0, 32'h0036, 64'h1234,              64'h0,                  5'd15, 0, 0, 0, 0, 32'h0030, 8'hC0, 64'h1234_1234_1234_1234, 64'h0,             2};

        rstn = 1'b0;
        for (int k = 0; k < 3; k++) begin
            reqValid[k] = 1'b0; reqWe[k] = 1'b0; reqSize[k] = 2'd0; reqUns[k] = 1'b0;
            reqAddr[k] = '0; reqWdata[k] = '0; reqRd[k] = '0;
            memGnt[k] = 1'b0; memRvalid[k] = 1'b0; memRdata[k] = '0; memErr[k] = 1'b0;
        end
        @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            curVec = 300 + k;
            checkOutput("rstCtrl", 64'({outs[k].stall, outs[k].rdsValid, outs[k].mis, outs[k].err,
                                        outs[k].memReq, outs[k].memWe, outs[k].memBe}), 64'd0);
            checkOutput("rstData", outs[k].rdsData, 64'd0);
            checkOutput("rstAddr", 64'(outs[k].memAddr), 64'd0);
            checkOutput("rstWdata", outs[k].memWdata, 64'd0);
            checkOutput("rstRd", 64'(outs[k].rdsRd), 64'd0);
        end
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 14; i++) begin
            curVec = i;
            applyStimulus(vecs[i]);
        end

        for (int i = 0; i < 150; i++) begin
            curVec    = 100 + i;
            rv        = '{default: 0};
            rv.inst   = $urandom_range(0, 2);
            rv.we     = 1'($urandom_range(0, 1));
            rv.size   = 2'($urandom_range(0, 3));
            rv.uns    = 1'($urandom_range(0, 1));
            rv.addr   = $urandom & 32'h0000_0FFF;
            if ($urandom_range(0, 3) != 0) rv.addr = rv.addr & ~((32'd1 << rv.size) - 32'd1);
            rv.wdata  = {$urandom, $urandom};
            rv.rdata  = {$urandom, $urandom};
            rv.rd     = 5'($urandom_range(0, 31));
            rv.gntDly = $urandom_range(0, 3);
            rv.rvDly  = $urandom_range(0, 3);
            rv.err    = ($urandom_range(0, 7) == 0);
            applyStimulus(fillExpected(rv));
        end

        resetDuringAccess(1'b1);
        resetDuringAccess(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Parametrised load/store unit between the pipeline's MEM stage and a data memory with variable latency, replacing the fixed single-cycle data-memory port. It aligns addresses, generates byte enables, and extracts and extends load data for a configurable data width and endianness. It runs a request/grant/response handshake toward memory and stalls the pipeline through the hazard unit until each access completes. Misaligned and illegal-size accesses are flagged without touching memory.

## Interface
Parameters:
- MP_DATA_WIDTH, 32: memory and register data width; 32 or 64. NB = MP_DATA_WIDTH/8 byte lanes.
- MP_ADDR_WIDTH, 32: byte-address width.
- MP_ENDIANESS, `RISCV_BIG_ENDIAN: byte-lane ordering; `RISCV_LITTLE_ENDIAN also supported.

Ports:
- iclk  in  1  clock; all state updates on the rising edge.
- irstn  in  1  reset, asynchronous assert, active low.
- ireq_valid  in  1  MEM-stage access present; held stable while ostall=1.
- ireq_we  in  1  1 = store, 0 = load.
- ireq_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (dword legal only when MP_DATA_WIDTH=64).
- ireq_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- ireq_addr  in  MP_ADDR_WIDTH  byte address.
- ireq_wdata  in  MP_DATA_WIDTH  store data, right-justified.
- ird  in  5  load destination register.
- ostall  out  1  stall IF/ID/EX/MEM to the hazard unit.
- ords_valid  out  1  one-cycle pulse: load result valid.
- ords_rd  out  5  destination register for ords_data.
- ords_data  out  MP_DATA_WIDTH  extended load result.
- omisaligned  out  1  one-cycle pulse: misaligned or illegal-size access.
- oerr  out  1  one-cycle pulse: memory reported an error.
- omem_req  out  1  memory request.
- omem_we  out  1  memory write.
- omem_addr  out  MP_ADDR_WIDTH  address with the low log2(NB) bits forced to 0.
- omem_be  out  NB  byte enables.
- omem_wdata  out  MP_DATA_WIDTH  store data replicated across lanes.
- imem_gnt  in  1  request accepted.
- imem_rvalid  in  1  load data valid.
- imem_rdata  in  MP_DATA_WIDTH  load data.
- imem_err  in  1  error, qualified by imem_gnt for stores and by imem_rvalid for loads.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- Alignment: offset = addr[log2(NB)-1:0]. The access is misaligned if offset mod (1<<size) != 0, or if size=3 with NB=4.
- IDLE:
  - ireq_valid and aligned: register the request, go to REQ.
  - ireq_valid and misaligned: pulse omisaligned, no memory access, stay in IDLE.
- REQ:
  - omem_req=1 with the registered address, we, be and wdata.
  - On imem_gnt, a store goes to DONE and latches imem_err.
  - On imem_gnt, a load goes to WAIT.
- WAIT: on imem_rvalid, register the formatted data and imem_err, go to DONE. imem_rvalid is ignored in every other state.
- DONE:
  - Load without error: ords_valid=1 for one cycle.
  - Any error: oerr=1 and ords_valid=0.
  - Always returns to IDLE. The still-present ireq_valid for the same instruction is not re-accepted.
- ostall = (IDLE & ireq_valid & aligned) | REQ | WAIT.
- Lane select:
  - Little-endian: first lane = offset.
  - Big-endian: first lane = NB - (1<<size) - offset.
  - omem_be sets (1<<size) contiguous bits starting at the first lane.
- Load extract: take (1<<size) bytes from the first lane and shift them to LSB. Within a multi-byte field, lane order follows MP_ENDIANESS. Sign- or zero-extend to MP_DATA_WIDTH.

## Timing
- Reset values: state IDLE; omem_req, omem_we, omem_be, ords_valid, omisaligned and oerr are 0; omem_addr, omem_wdata, ords_rd and ords_data are 0.
- ostall follows ireq_valid combinationally in IDLE.
- Store latency: minimum 3 cycles from ireq_valid (accept, grant, DONE). Each extra grant-wait cycle adds one.
- Load latency: minimum 4 cycles; imem_rvalid arrives no earlier than the cycle after imem_gnt.
- omem_req and its attributes stay stable from REQ entry until imem_gnt is sampled high.
- Misaligned flag: omisaligned is combinational in the same cycle as ireq_valid; ostall stays 0.
- Reset mid-access: all state is abandoned and omem_req drops asynchronously. An outstanding load's imem_rvalid after reset is ignored.

## Test plan
- LE, 32-bit: load byte at 0x1003 with imem_rdata=0x80_00_00_00, unsigned=0 → omem_addr=0x1000, omem_be=4'b1000, ords_data=0xFFFF_FF80 one cycle after rvalid, ostall high for 3 cycles.
- BE, 32-bit: store half 0xBEEF at 0x2002 → omem_be=4'b0011, omem_wdata=0xBEEF_BEEF; gnt delayed 2 cycles, so ostall is high for 4 cycles and no ords_valid.
- Misaligned: word load at 0x1002 → omisaligned pulse, omem_req never asserted, ostall=0.
- 64-bit, LE: dword load at 0x8 → omem_be=8'hFF, ords_data=imem_rdata; the same request at 0x4 → omisaligned.
- Error path: load with imem_rvalid & imem_err → oerr pulse, ords_valid stays 0, FSM back to IDLE.
- Reset during WAIT: irstn low → omem_req=0 and ostall=0 immediately; a later imem_rvalid produces no ords_valid.
